// File: rtl/seg7_capture_if.sv
// Scanned 7-segment bus plus the decoded results read back from it.
// The master drives seg/segsel; the capture block (slave) returns the decoded frame.
interface seg7_capture_if;
   logic [7:0]  seg;
   logic [3:0]  segsel;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        valid;
   logic        err;
   logic        stale;

   modport master (output seg, segsel, input value, dp, valid, err, stale);
   modport slave  (input seg, segsel, output value, dp, valid, err, stale);
endinterface

// File: rtl/seg7_capture.sv
// Decodes a multiplexed 4-digit 7-segment scan back into a 16-bit value.
// Digits are captured once stable, and a frame is published after it repeats.
module seg7_capture #(
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter int unsigned SETTLE         = 16,
   parameter int unsigned MATCH_FRAMES   = 2,
   parameter int unsigned TIMEOUT        = 2000000
) (
   input  logic          clk,
   input  logic          reset,
   seg7_capture_if.slave bus
);

   localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW}};
   localparam logic [3:0] SEL_INV = {4{SEL_ACTIVE_LOW}};
   localparam logic [7:0] SETTLE_C = 8'(SETTLE);
   localparam logic [3:0] MF_C = 4'(MATCH_FRAMES);
   localparam logic [31:0] TMO_C = 32'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

   logic [7:0]  seg_s1, seg_s2;
   logic [3:0]  sel_s1, sel_s2;
   logic [7:0]  seg_n;
   logic [3:0]  sel_n;
   logic [11:0] prev;
   logic [7:0]  stab;
   state_t      state;
   logic [15:0] dig;
   logic [3:0]  dpd;
   logic [3:0]  seen;
   logic [19:0] cand;
   logic [3:0]  mcnt;
   logic [31:0] scnt;

   // Synchronizers idle at the inactive pin level so reset looks like blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_s1 <= SEG_INV;
         seg_s2 <= SEG_INV;
         sel_s1 <= SEL_INV;
         sel_s2 <= SEL_INV;
      end else begin
         seg_s1 <= bus.seg;
         seg_s2 <= seg_s1;
         sel_s1 <= bus.segsel;
         sel_s2 <= sel_s1;
      end
   end

   assign seg_n = seg_s2 ^ SEG_INV;
   assign sel_n = sel_s2 ^ SEL_INV;

   function automatic logic [4:0] decode(input logic [6:0] g);
      case (g)
         7'h3F:   decode = {1'b1, 4'h0};
         7'h06:   decode = {1'b1, 4'h1};
         7'h5B:   decode = {1'b1, 4'h2};
         7'h4F:   decode = {1'b1, 4'h3};
         7'h66:   decode = {1'b1, 4'h4};
         7'h6D:   decode = {1'b1, 4'h5};
         7'h7D:   decode = {1'b1, 4'h6};
         7'h07:   decode = {1'b1, 4'h7};
         7'h7F:   decode = {1'b1, 4'h8};
         7'h6F:   decode = {1'b1, 4'h9};
         7'h77:   decode = {1'b1, 4'hA};
         7'h7C:   decode = {1'b1, 4'hB};
         7'h39:   decode = {1'b1, 4'hC};
         7'h5E:   decode = {1'b1, 4'hD};
         7'h79:   decode = {1'b1, 4'hE};
         7'h71:   decode = {1'b1, 4'hF};
         default: decode = {1'b0, 4'h0};
      endcase
   endfunction

   logic        change, capture, onehot, good, bad, complete, match, publish;
   logic [4:0]  glyph;
   logic [15:0] dig_nx;
   logic [3:0]  dpd_nx, seen_nx;
   logic [19:0] frame;
   logic [7:0]  stab_nx;
   logic [31:0] scnt_nx;

   always_comb begin
      change  = {sel_n, seg_n} != prev;
      capture = (state == S_SETTLE) && !change && (stab == SETTLE_C);
      glyph   = decode(seg_n[6:0]);
      onehot  = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
      good    = capture && onehot && glyph[4];
      bad     = capture && !(onehot && glyph[4]);
      dig_nx  = dig;
      dpd_nx  = dpd;
      seen_nx = seen;
      for (int unsigned i = 0; i < 4; i++) begin
         if (good && sel_n[i]) begin
            dig_nx[4*i +: 4] = glyph[3:0];
            dpd_nx[i]        = seg_n[7];
            seen_nx[i]       = 1'b1;
         end
      end
      if (bad)
         seen_nx = '0;
      complete = good && (seen_nx == 4'b1111);
      frame    = {dpd_nx, dig_nx};
      match    = frame == cand;
      // Strobe only on the step into MATCH_FRAMES, never while saturated there.
      publish  = complete && (match ? ((mcnt != MF_C) && (mcnt + 4'd1 == MF_C))
                                    : (MF_C == 4'd1));
      stab_nx  = change ? 8'd1 : ((stab >= SETTLE_C) ? stab : stab + 8'd1);
      scnt_nx  = (scnt >= TMO_C) ? scnt : scnt + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev      <= '0;
         stab      <= '0;
         state     <= S_IDLE;
         dig       <= '0;
         dpd       <= '0;
         seen      <= '0;
         cand      <= '0;
         mcnt      <= '0;
         scnt      <= '0;
         bus.value <= '0;
         bus.dp    <= '0;
         bus.valid <= 1'b0;
         bus.err   <= 1'b0;
         bus.stale <= 1'b1;
      end else begin
         prev    <= {sel_n, seg_n};
         stab    <= stab_nx;
         bus.err <= bad;
         dig     <= dig_nx;
         dpd     <= dpd_nx;
         seen    <= complete ? 4'd0 : seen_nx;

         if (change)
            state <= (sel_n != 4'd0) ? S_SETTLE : S_IDLE;
         else if (capture)
            state <= S_DONE;

         if (complete) begin
            if (match) begin
               if (mcnt != MF_C)
                  mcnt <= mcnt + 4'd1;
            end else begin
               cand <= frame;
               mcnt <= 4'd1;
            end
         end

         bus.valid <= publish;
         if (publish) begin
            bus.value <= frame[15:0];
            bus.dp    <= frame[19:16];
         end

         // Stale latches high at the timeout and only a completed frame lowers it.
         if (complete) begin
            scnt      <= '0;
            bus.stale <= 1'b0;
         end else begin
            scnt      <= scnt_nx;
            bus.stale <= bus.stale | (scnt_nx >= TMO_C);
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: drives active-low scans and scores published frames.
// Expected publishes are queued with the cycle they must appear on.
module tb_seg7_capture;

   localparam int unsigned SETTLE = 16;
   localparam int unsigned MF     = 2;
   localparam int unsigned TMO    = 1000;
   localparam int unsigned SLOT   = 100;
   localparam int unsigned LAT    = SETTLE + 3;
   localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic reset = 1'b0;
   int unsigned cyc = 0;
   int tests = 0;
   int fails = 0;
   int err_seen = 0;

   typedef struct {
      logic [15:0] v;
      logic [3:0]  d;
      int unsigned at;
   } exp_t;
   exp_t sb[$];

   seg7_capture_if bus ();

   seg7_capture #(
      .SEG_ACTIVE_LOW(1'b1),
      .SEL_ACTIVE_LOW(1'b1),
      .SETTLE(SETTLE),
      .MATCH_FRAMES(MF),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.err === 1'b1) err_seen++;
      if (bus.valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid_queue", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("valid_value", bus.value, e.v);
            chk("valid_dp", bus.dp, e.d);
            chk("valid_cycle", cyc, e.at);
         end
      end
   end

   task automatic drive(input logic [3:0] selh, input logic [7:0] segh);
      bus.segsel = ~selh;
      bus.seg    = ~segh;
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic digit(input int unsigned d, input logic [15:0] v, input logic [3:0] dpv,
                        input bit bad, input bit push);
      logic [7:0] s;
      s = bad ? 8'h00 : {dpv[d], GL[v[4*d +: 4]]};
      drive(4'b0001 << d, s);
      if (push) sb.push_back('{v, dpv, cyc + LAT});
      wait_clk(SLOT);
   endtask

   task automatic frame(input logic [15:0] v, input logic [3:0] dpv, input bit ghost,
                        input int bad_d, input int push_d);
      for (int d = 0; d < 4; d++) begin
         if (ghost) begin
            drive((4'b0001 << d) | (4'b0001 << ((d + 3) % 4)),
                  {1'b0, GL[v[4*d +: 4]] | GL[15]});
            wait_clk(5);
         end
         digit(d, v, dpv, bad_d == d, push_d == d);
      end
   endtask

   initial begin
      drive(4'd0, 8'd0);
      #5 reset = 1'b1;
      wait_clk(3);
      chk("reset_value", bus.value, 16'h0000);
      chk("reset_dp", bus.dp, 4'h0);
      chk("reset_valid", bus.valid, 1'b0);
      chk("reset_err", bus.err, 1'b0);
      chk("reset_stale", bus.stale, 1'b1);
      reset = 1'b0;
      wait_clk(1);

      // Basic scan: publish on the second identical frame only.
      frame(16'h12AB, 4'h0, 1'b0, -1, -1);
      chk("stale_after_first_frame", bus.stale, 1'b0);
      frame(16'h12AB, 4'h0, 1'b0, -1, 3);
      frame(16'h12AB, 4'h0, 1'b0, -1, -1);
      chk("basic_value", bus.value, 16'h12AB);
      chk("basic_dp", bus.dp, 4'h0);
      chk("basic_pending", sb.size(), 0);
      chk("basic_no_err", err_seen, 0);

      // Blanking after a publish: stale rises TIMEOUT clocks after the last frame.
      drive(4'd0, 8'd0);
      wait_clk(900);
      chk("stale_before_timeout", bus.stale, 1'b0);
      wait_clk(30);
      chk("stale_after_timeout", bus.stale, 1'b1);
      chk("stale_value_kept", bus.value, 16'h12AB);
      frame(16'h12AB, 4'h0, 1'b0, -1, -1);
      chk("stale_cleared_on_resume", bus.stale, 1'b0);

      // Ghosting between slots, then a value change.
      frame(16'h12AB, 4'h0, 1'b1, -1, -1);
      frame(16'h12AC, 4'h0, 1'b1, -1, -1);
      frame(16'h12AC, 4'h0, 1'b1, -1, 3);
      frame(16'h12AC, 4'h0, 1'b1, -1, -1);
      chk("ghost_no_err", err_seen, 0);
      chk("ghost_value", bus.value, 16'h12AC);
      chk("ghost_pending", sb.size(), 0);

      // Blank glyph on digit 2: one error per frame, nothing published.
      frame(16'h12AC, 4'h0, 1'b0, 2, -1);
      chk("badglyph_err_1", err_seen, 1);
      frame(16'h12AC, 4'h0, 1'b0, 2, -1);
      chk("badglyph_err_2", err_seen, 2);
      chk("badglyph_value_held", bus.value, 16'h12AC);

      // Multi-hot select aborts the partial frame; frame boundaries re-align after it.
      digit(0, 16'h5E3D, 4'b0101, 1'b0, 1'b0);
      digit(1, 16'h5E3D, 4'b0101, 1'b0, 1'b0);
      drive(4'b0011, {1'b0, GL[8]});
      wait_clk(100);
      chk("multihot_err", err_seen, 3);
      digit(2, 16'h5E3D, 4'b0101, 1'b0, 1'b0);
      digit(3, 16'h5E3D, 4'b0101, 1'b0, 1'b0);
      frame(16'h5E3D, 4'b0101, 1'b0, -1, -1);
      frame(16'h5E3D, 4'b0101, 1'b0, -1, 1);
      chk("multihot_value", bus.value, 16'h5E3D);
      chk("multihot_dp", bus.dp, 4'b0101);
      chk("multihot_pending", sb.size(), 0);

      // Asynchronous reset mid-frame.
      digit(0, 16'h9F07, 4'h0, 1'b0, 1'b0);
      digit(1, 16'h9F07, 4'h0, 1'b0, 1'b0);
      drive(4'b0100, {1'b0, GL[15]});
      wait_clk(10);
      reset = 1'b1;
      #1;
      chk("midreset_value", bus.value, 16'h0000);
      chk("midreset_dp", bus.dp, 4'h0);
      chk("midreset_valid", bus.valid, 1'b0);
      chk("midreset_stale", bus.stale, 1'b1);
      drive(4'd0, 8'd0);
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);
      frame(16'h9F07, 4'h0, 1'b0, -1, -1);
      frame(16'h9F07, 4'h0, 1'b0, -1, 3);
      chk("postreset_value", bus.value, 16'h9F07);
      chk("postreset_err", err_seen, 3);

      wait_clk(5);
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
